xor_stream_accum: RTL

- Parameterised, registered successor to the bitwise XOR gate.
- Takes CHANNELS input lanes of WIDTH bits per beat and XORs all lanes bitwise.
- Output is either per beat (pass mode) or accumulated over a packet, ending at IN_LAST (accumulate mode).
- Sits in datapath checksum/scrambler paths; valid/ready on both sides, one registered output stage.

---
 rtl/xor_stream_accum.sv | 136 +++++++++++++
 1 files changed

// File: rtl/xor_stream_accum.sv
// xor_stream_accum: registered bitwise XOR of CHANNELS lanes, per beat (MODE=0) or folded
// over a packet ending at IN_LAST (MODE=1). Define XOR_STREAM_PARITY_EN to add OUT_PARITY.
module xor_stream_accum #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      CLR,
  input  logic                      MODE,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic                      IN_LAST,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [WIDTH-1:0]          OUT_DATA,
  output logic                      OUT_LAST,
  output logic [CNT_W-1:0]          OUT_COUNT,
`ifdef XOR_STREAM_PARITY_EN
  output logic                      OUT_PARITY,
`endif
  output logic                      dbg_state
);

  // Handshake: a beat transfers on a rising edge where IN_VALID && IN_READY; a result
  // transfers where OUT_VALID && OUT_READY. A held result blocks new beats, and a result
  // may be consumed and replaced on the same edge.
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [WIDTH-1:0]   lane_xor;
  logic               accept;
  logic               load;
  logic [WIDTH-1:0]   load_data;
  logic               load_last;
  logic [CNT_W-1:0]   load_cnt;

  always_comb begin
    lane_xor = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lane_xor = lane_xor ^ IN_DATA[k*WIDTH +: WIDTH];
    end
  end

  assign IN_READY  = RSTn && !CLR && (!OUT_VALID || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign dbg_state = (state == ACCUM);

  // MODE only matters for the first beat of a packet; once in ACCUM it is ignored.
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    load      = 1'b0;
    load_data = lane_xor;
    load_last = IN_LAST;
    load_cnt  = CNT_W'(1);
    if (CLR) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (MODE && !IN_LAST) begin
            state_n = ACCUM;
            acc_n   = lane_xor;
            cnt_n   = CNT_W'(1);
          end else begin
            load = 1'b1;
          end
        end
        ACCUM: begin
          if (IN_LAST) begin
            load      = 1'b1;
            load_data = acc ^ lane_xor;
            load_last = 1'b1;
            load_cnt  = cnt_inc;
            state_n   = IDLE;
            acc_n     = '0;
            cnt_n     = '0;
          end else begin
            acc_n = acc ^ lane_xor;
            cnt_n = cnt_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
    end
  end

  // Load only happens on an accept, which already implies the old result is gone or leaving.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_LAST  <= 1'b0;
      OUT_COUNT <= '0;
    end else if (load) begin
      OUT_VALID <= 1'b1;
      OUT_DATA  <= load_data;
      OUT_LAST  <= load_last;
      OUT_COUNT <= load_cnt;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

`ifdef XOR_STREAM_PARITY_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      OUT_PARITY <= 1'b0;
    end else if (load) begin
      OUT_PARITY <= ^load_data;
    end
  end
`endif

endmodule
